// File: rtl/ks_adder_pipe.sv
// ks_adder_pipe
//   Fully pipelined Kogge-Stone adder/subtractor on a valid/ready stream.
//   One register for operand pre-processing (generate/propagate), one
//   register per prefix layer, and one output register: latency
//   LOG2W + 2 cycles, one result per cycle when the consumer keeps up.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready operand beat handshake
//   a, b, cin, sub    operands; sub=0: a+b+cin, sub=1: a-b-cin
//   out_valid/out_ready result handshake
//   sum, cout, ovf    result, carry-out (sub: 1 = no borrow), signed overflow
//
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high. Once raised, out_valid and the result stay unchanged until the edge
// that consumes the result. in_ready is combinational from out_ready: the whole
// pipeline stalls as one while a result waits. There is no skid buffer.

module ks_adder_pipe #(
  parameter  int WIDTH = 16,
  localparam int LOG2W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  // Stage k registers (k = 0 .. LOG2W). p_q/ci_q are the original bit
  // propagates and carry-in, carried unchanged to the sum stage. g_q/pr_q
  // are the group generate/propagate after k prefix layers. The group
  // propagate of the final layer is never consumed, so pr_q stops one short.
  logic [WIDTH-1:0] p_q  [0:LOG2W];
  logic [WIDTH-1:0] g_q  [0:LOG2W];
  logic [WIDTH-1:0] pr_q [0:LOG2W-1];
  logic [LOG2W:0]   ci_q;
  logic [LOG2W:0]   v_q;

  logic [WIDTH-1:0] p_nx  [0:LOG2W];
  logic [WIDTH-1:0] g_nx  [0:LOG2W];
  logic [WIDTH-1:0] pr_nx [0:LOG2W-1];
  logic [LOG2W:0]   ci_nx;
  logic [LOG2W:0]   v_nx;

  logic             stall;
  logic [WIDTH-1:0] bb;
  logic             ci_in;
  logic [WIDTH-1:0] c;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // Subtraction as a + ~b + ~cin.
  assign bb    = sub ? ~b : b;
  assign ci_in = sub ? ~cin : cin;

  always_comb begin
    // Stage 0: bitwise generate/propagate, carry-in folded into G[0].
    p_nx[0]     = a ^ bb;
    g_nx[0]     = a & bb;
    g_nx[0][0]  = (a[0] & bb[0]) | ((a[0] ^ bb[0]) & ci_in);
    pr_nx[0]    = a ^ bb;
    ci_nx[0]    = ci_in;
    v_nx[0]     = in_valid;

    // Layer k combines with the span 2^(k-1) below. Shifting left brings
    // bit i-d into position i; the low d bits get G unchanged (shifted-in
    // zeros) and P unchanged (OR with an all-ones low mask).
    for (int k = 1; k <= LOG2W; k++) begin
      g_nx[k]  = g_q[k-1] | (pr_q[k-1] & (g_q[k-1] << (1 << (k-1))));
      p_nx[k]  = p_q[k-1];
      ci_nx[k] = ci_q[k-1];
      v_nx[k]  = v_q[k-1];
    end
    for (int k = 1; k < LOG2W; k++) begin
      pr_nx[k] = pr_q[k-1] &
                 ((pr_q[k-1] << (1 << (k-1))) | (ONES >> (WIDTH - (1 << (k-1)))));
    end
  end

  // Carry out of each bit position after the last prefix layer.
  assign c = g_q[LOG2W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= LOG2W; k++) begin
        p_q[k] <= '0;
        g_q[k] <= '0;
      end
      for (int k = 0; k < LOG2W; k++) begin
        pr_q[k] <= '0;
      end
      ci_q      <= '0;
      v_q       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      // Every stage shifts, bubbles included, so ordering is preserved.
      for (int k = 0; k <= LOG2W; k++) begin
        p_q[k] <= p_nx[k];
        g_q[k] <= g_nx[k];
      end
      for (int k = 0; k < LOG2W; k++) begin
        pr_q[k] <= pr_nx[k];
      end
      ci_q      <= ci_nx;
      v_q       <= v_nx;
      sum       <= p_q[LOG2W] ^ {c[WIDTH-2:0], ci_q[LOG2W]};
      cout      <= c[WIDTH-1];
      ovf       <= c[WIDTH-1] ^ c[WIDTH-2];
      out_valid <= v_q[LOG2W];
    end
  end

endmodule

// File: tb/tb_ks_adder_pipe.sv
// tb_ks_adder_pipe
//   Directed and streaming checks of ks_adder_pipe at WIDTH 16, plus a
//   carry-ripple vector at WIDTH 4 and 64. Inputs are driven 1 ns after the
//   rising edge; the stream monitor samples on the falling edge.

module tb_ks_adder_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- WIDTH=16 DUT ----------------
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;

  ks_adder_pipe #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  // ---------------- WIDTH=4 DUT ----------------
  logic       v4_in_valid, v4_in_ready, v4_out_valid, v4_cout, v4_ovf;
  logic [3:0] v4_a, v4_b, v4_sum;

  ks_adder_pipe #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v4_in_valid), .in_ready(v4_in_ready),
    .a(v4_a), .b(v4_b), .cin(1'b1), .sub(1'b0),
    .out_valid(v4_out_valid), .out_ready(1'b1),
    .sum(v4_sum), .cout(v4_cout), .ovf(v4_ovf)
  );

  // ---------------- WIDTH=64 DUT ----------------
  logic        v64_in_valid, v64_in_ready, v64_out_valid, v64_cout, v64_ovf;
  logic [63:0] v64_a, v64_b, v64_sum;

  ks_adder_pipe #(.WIDTH(64)) u64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v64_in_valid), .in_ready(v64_in_ready),
    .a(v64_a), .b(v64_b), .cin(1'b1), .sub(1'b0),
    .out_valid(v64_out_valid), .out_ready(1'b1),
    .sum(v64_sum), .cout(v64_cout), .ovf(v64_ovf)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural model, packed as {ovf, cout, sum}.
  function automatic logic [17:0] model16(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mcin, input logic msub);
    logic [15:0] mbb;
    logic [16:0] r;
    logic        mo;
    mbb = msub ? ~mb : mb;
    r   = {1'b0, ma} + {1'b0, mbb} + {16'd0, (msub ? ~mcin : mcin)};
    mo  = (ma[15] == mbb[15]) && (r[15] != ma[15]);
    return {mo, r[16], r[15:0]};
  endfunction

  // ---------------- scoreboard ----------------
  logic [17:0] exp_q[$];
  bit mon_en  = 1'b0;
  int n_push  = 0;
  int n_pop   = 0;
  int n_stall = 0;
  int first_t = -1;
  int last_t  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model16(a, b, cin, sub));
        n_push++;
      end
      if (out_valid && !out_ready) begin
        n_stall++;
        check("in_ready_stall", in_ready, 0);
        if (exp_q.size() == 0) check("stall_empty_q", 1, 0);
        else                   check("stall_hold", {ovf, cout, sum}, exp_q[0]);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious", 1, 0);
        end else begin
          check("result", {ovf, cout, sum}, exp_q.pop_front());
          n_pop++;
          if (first_t < 0) first_t = cyc;
          last_t = cyc;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) tick();
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic dir16(input logic [15:0] ta, input logic [15:0] tb, input logic tcin,
                       input logic tsub, input logic [15:0] esum, input logic ecout,
                       input logic eovf);
    int n;
    in_valid = 1'b1; a = ta; b = tb; cin = tcin; sub = tsub; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("lat16", n, 6);
    check("sum16", sum, esum);
    check("cout16", cout, ecout);
    check("ovf16", ovf, eovf);
    tick();
  endtask

  task automatic sweep();
    int l4, l64;
    l4 = 0; l64 = 0;
    v4_in_valid  = 1'b1; v4_a  = 4'hF;       v4_b  = 4'h1;
    v64_in_valid = 1'b1; v64_a = {64{1'b1}}; v64_b = 64'd1;
    tick();
    v4_in_valid = 1'b0; v64_in_valid = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (l4 == 0 && v4_out_valid) begin
        l4 = n;
        check("sum4", v4_sum, 1);
        check("cout4", v4_cout, 1);
        check("ovf4", v4_ovf, 0);
      end
      if (l64 == 0 && v64_out_valid) begin
        l64 = n;
        check("sum64", v64_sum, 1);
        check("cout64", v64_cout, 1);
        check("ovf64", v64_ovf, 0);
      end
      tick();
    end
    check("lat4", l4, 4);
    check("lat64", l64, 8);
  endtask

  task automatic rand_ops();
    a   = 16'($urandom);
    b   = 16'($urandom);
    cin = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int stale;
    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    v4_in_valid = 1'b0; v4_a = '0; v4_b = '0;
    v64_in_valid = 1'b0; v64_a = '0; v64_b = '0;

    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_in_ready4", v4_in_ready, 1);
    check("rst_in_ready64", v64_in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed vectors: {a, b, cin, sub} -> {sum, cout, ovf}
    dir16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    dir16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    dir16(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    dir16(16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    dir16(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
    dir16(16'h5555, 16'h1111, 1'b1, 1'b1, 16'h4443, 1'b1, 1'b0);

    // Width sweep
    sweep();

    // Streaming, no gaps
    n_pop = 0; first_t = -1; mon_en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      in_valid = 1'b1;
      rand_ops();
      tick();
    end
    in_valid = 1'b0;
    drain();
    check("stream_count", n_pop, 200);
    check("stream_gapless", last_t - first_t, 199);

    // Backpressure with two 3-cycle stalls on a full pipeline
    n_push = 0; n_pop = 0; n_stall = 0;
    for (int c = 0; c < 60; c++) begin
      in_valid  = (c < 20 || (c >= 30 && c < 40)) ? 1'b1 : 1'($urandom_range(0, 1));
      rand_ops();
      out_ready = !((c >= 20 && c < 23) || (c >= 40 && c < 43));
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain();
    check("bp_stalls", n_stall, 6);
    check("bp_count", n_pop, n_push);

    // Reset mid-stream
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      rand_ops();
      tick();
    end
    check("pre_reset_valid", out_valid, 1);
    #2;
    mon_en = 1'b0;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_sum", sum, 0);
    check("mid_rst_cout", cout, 0);
    check("mid_rst_ovf", ovf, 0);
    check("mid_rst_in_ready", in_ready, 1);
    exp_q.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) stale++;
    end
    check("no_stale", stale, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ks_adder_pipe.md
# ks_adder_pipe

Parametrised, fully pipelined Kogge-Stone adder/subtractor with a valid/ready stream interface. It generalises the fixed 16-bit combinational prefix-layer adder to any power-of-two width. It adds a subtract mode with borrow, signed-overflow detection, and backpressure. Each prefix layer is registered, so the block sits on the datapath's arithmetic stream at one result per cycle.

## Interface
- WIDTH, 16: operand width; power of two, 2..64
- LOG2W, $clog2(WIDTH): number of prefix layers; derived, not overridden
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat present
- in_ready  out  1  block accepts beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (add) / borrow-in (sub)
- sub  in  1  0: a+b+cin; 1: a-b-cin
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  carry-out; in sub mode 1 = no borrow
- ovf  out  1  two's-complement overflow

## Operation
- Beat accepted on a rising edge when in_valid && in_ready.
- Stage 0 (register): bb = sub ? ~b : b; ci = sub ? ~cin : cin; p = a ^ bb; g = a & bb; G[0] |= p[0] & ci (carry-in folded); P[0] = p[0]; register p, ci, P, G and valid.
- Stages 1..LOG2W (register each): distance d = 2^(k-1). For i >= d: G'[i] = G[i] | (P[i] & G[i-d]); P'[i] = P[i] & P[i-d]. For i < d: pass through. Original p and ci travel alongside unchanged.
- Final stage (register): C = G after the last layer. sum[0] = p[0] ^ ci; sum[i] = p[i] ^ C[i-1]. cout = C[WIDTH-1]; ovf = C[WIDTH-1] ^ C[WIDTH-2]. For WIDTH=2, C[0] is used as C[WIDTH-2].
- Each stage carries a valid bit. Bubbles propagate as invalid entries and are not compressed.
- Global stall: stall = out_valid && !out_ready. in_ready = !stall, combinational from out_ready. When stall is high, every stage register holds its value.
- When not stalled, all stages shift by one, including invalid entries.
- Results emerge in acceptance order; there is no reordering, loss or duplication.
- Reset (rst_n low, asynchronous): all valid bits, sum, cout, ovf, out_valid go to 0 immediately. Internal data registers also clear to 0. In-flight beats are discarded. in_ready reads 1 whenever out_valid is 0.

## Timing
- Latency L = LOG2W + 2 cycles from the accepting edge to the edge that raises out_valid, with no stall. L = 6 for WIDTH=16 and L = 8 for WIDTH=64.
- Each stall cycle adds exactly 1 to the latency of every in-flight beat.
- Throughput: 1 beat/cycle while out_ready = 1.
- Output hold: sum, cout and ovf are stable and out_valid stays high until the edge where out_ready = 1.
- The beat at the output is consumed on that edge. On the same edge a new beat may be accepted.
- in_ready drops in the same cycle out_ready drops while out_valid = 1; there is no skid.
- Deassertion of rst_n is synchronised externally; the first acceptance is allowed on the first edge after release.
- Critical path per stage: one AND-OR level.

## Test plan
- Reset mid-stream: pipeline full, pull rst_n low between edges. Required: out_valid, sum, cout, ovf = 0 immediately; in_ready = 1. After release, no stale result appears within 2L cycles of idle.
- WIDTH=16 add: a=0xFFFF, b=0x0001, cin=0, sub=0. Required: out_valid on edge 6, sum=0x0000, cout=1, ovf=0. Also a=0x7FFF, b=0x0001 gives sum=0x8000, cout=0, ovf=1.
- WIDTH=16 subtract: a=0x8000, b=0x0001, cin=0, sub=1. Required: sum=0x7FFF, cout=1, ovf=1. Also a=0x0000, b=0x0001, cin=0 gives sum=0xFFFF, cout=0 (borrow), ovf=0.
- Streaming: 200 random beats with random sub/cin, in_valid always 1, out_ready always 1. Required: one result per cycle after the first 6; all match a behavioural a±b±cin model in order.
- Backpressure: full pipeline, out_ready = 0 for 3 cycles, random in_valid gaps. Required: sum held constant, in_ready = 0 during the stall; all results delivered exactly once and in order.
- Parameter sweep, WIDTH=4 then 64: a=all-ones, b=1, cin=1, add. Required: sum=1, cout=1, ovf=0. Latency is 4 for WIDTH=4 and 8 for WIDTH=64.
